// File: rtl/arm7tdmi_psr_unit.sv
// rtl/arm7tdmi_psr_unit.sv - ARM7TDMI CPSR/banked SPSR block with condition evaluation
// Only NZCV, I, F, T and mode are stored; all other bits stay zero.
module arm7tdmi_psr_unit #(
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_flags_we,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic [3:0]  cond,
  output logic        cond_pass,
  input  logic        msr_we,
  input  logic        msr_spsr,
  input  logic [3:0]  msr_mask,
  input  logic [31:0] msr_data,
  input  logic        exc_enter,
  input  logic [4:0]  exc_mode,
  input  logic        exc_set_f,
  input  logic        spsr_restore,
  input  logic        t_we,
  input  logic        t_val,
  output logic [31:0] cpsr,
  output logic [31:0] spsr,
  output logic        carry_flag,
  output logic        psr_err
);

  localparam logic [31:0] IMPL_MASK = 32'hF000_00FF;
  localparam logic [4:0]  MODE_USR  = 5'b10000;
  localparam logic [4:0]  MODE_FIQ  = 5'b10001;
  localparam logic [4:0]  MODE_IRQ  = 5'b10010;
  localparam logic [4:0]  MODE_SVC  = 5'b10011;
  localparam logic [4:0]  MODE_ABT  = 5'b10111;
  localparam logic [4:0]  MODE_UND  = 5'b11011;
  localparam logic [4:0]  MODE_SYS  = 5'b11111;

  function automatic logic has_spsr(input logic [4:0] m);
    return (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
           (m == MODE_ABT) || (m == MODE_UND);
  endfunction

  function automatic logic legal_mode(input logic [4:0] m);
    return has_spsr(m) || (m == MODE_USR) || (m == MODE_SYS);
  endfunction

  function automatic logic [2:0] spsr_idx(input logic [4:0] m);
    case (m)
      MODE_FIQ: return 3'd0;
      MODE_IRQ: return 3'd1;
      MODE_SVC: return 3'd2;
      MODE_ABT: return 3'd3;
      default:  return 3'd4;
    endcase
  endfunction

  logic [31:0] cpsr_q, cpsr_d;
  logic [31:0] spsr_q [5];
  logic [31:0] spsr_d [5];
  logic        err_q, err_d;
  logic [4:0]  cur_mode;
  logic        cur_has;
  logic [2:0]  cur_idx;
  logic [31:0] cur_spsr;
  logic        unused_fields;

  assign unused_fields = ^{msr_data[27:8], msr_mask[2:1]};

  assign cur_mode = cpsr_q[4:0];
  assign cur_has  = has_spsr(cur_mode);
  assign cur_idx  = spsr_idx(cur_mode);
  assign cur_spsr = spsr_q[cur_idx];

  always_comb begin
    cpsr_d = cpsr_q;
    spsr_d = spsr_q;
    err_d  = 1'b0;
    if (exc_enter) begin
      if (has_spsr(exc_mode)) begin
        spsr_d[spsr_idx(exc_mode)] = cpsr_q;
        cpsr_d[4:0] = exc_mode;
        cpsr_d[7]   = 1'b1;
        if (exc_set_f) cpsr_d[6] = 1'b1;
        cpsr_d[5]   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (spsr_restore) begin
      if (!cur_has) begin
        err_d = 1'b1;
      end else begin
        cpsr_d = cur_spsr;
        if (!legal_mode(cur_spsr[4:0])) begin
          cpsr_d[4:0] = cur_mode;
          err_d       = 1'b1;
        end
      end
    end else if (msr_we) begin
      if (!msr_spsr) begin
        if (msr_mask[3]) cpsr_d[31:28] = msr_data[31:28];
        // T is deliberately excluded from the CPSR control field write
        if (msr_mask[0] && (cur_mode != MODE_USR)) begin
          cpsr_d[7:6] = msr_data[7:6];
          if (legal_mode(msr_data[4:0])) cpsr_d[4:0] = msr_data[4:0];
          else                           err_d       = 1'b1;
        end
      end else if (!cur_has) begin
        err_d = 1'b1;
      end else begin
        if (msr_mask[3]) spsr_d[cur_idx][31:28] = msr_data[31:28];
        if (msr_mask[0]) begin
          spsr_d[cur_idx][7:5] = msr_data[7:5];
          if (legal_mode(msr_data[4:0])) spsr_d[cur_idx][4:0] = msr_data[4:0];
          else                           err_d                = 1'b1;
        end
      end
    end else if (t_we) begin
      cpsr_d[5] = t_val;
    end else if (alu_flags_we) begin
      cpsr_d[31:28] = {alu_n, alu_z, alu_c, alu_v};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpsr_q <= RESET_CPSR & IMPL_MASK;
      for (int i = 0; i < 5; i++) spsr_q[i] <= '0;
      err_q  <= 1'b0;
    end else begin
      cpsr_q <= cpsr_d;
      spsr_q <= spsr_d;
      err_q  <= err_d;
    end
  end

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = cpsr_q[31:28];

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign cpsr       = cpsr_q;
  assign spsr       = cur_has ? cur_spsr : 32'h0;
  assign carry_flag = cpsr_q[29];
  assign psr_err    = err_q;

endmodule

// File: doc/arm7tdmi_psr_unit.md
Name: arm7tdmi_psr_unit

Overview:
- Program status register block: holds CPSR and banked SPSRs (FIQ, IRQ, SVC, ABT, UND).
- Consumes the ALU flag outputs (N, Z, C, V) and feeds the current C flag back to the ALU as carry_in.
- Evaluates instruction condition codes for the decode/execute stage.
- Applies MSR writes, exception entry and SPSR-to-CPSR restore with fixed priority.

Parameters:
RESET_CPSR, 32'h0000_00D3, CPSR value loaded on reset (SVC mode, I=1, F=1, T=0, flags clear)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
alu_flags_we  in  1  latch ALU flags (instruction with S bit and condition passed)
alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flag results
cond  in  4  condition field of current instruction
cond_pass  out  1  condition satisfied by current CPSR flags
msr_we  in  1  MSR write strobe
msr_spsr  in  1  0 = target CPSR, 1 = target SPSR of current mode
msr_mask  in  4  field mask [3]=f(31:24) [2]=s [1]=x [0]=c(7:0)
msr_data  in  32  MSR write data
exc_enter  in  1  exception entry strobe
exc_mode  in  5  target exception mode
exc_set_f  in  1  also set F on entry (FIQ, reset)
spsr_restore  in  1  copy current SPSR to CPSR (exception return)
t_we, t_val  in  1 each  set T bit (BX)
cpsr  out  32  current CPSR
spsr  out  32  SPSR of current mode; 0 in USR/SYS
carry_flag  out  1  cpsr[29], drives ALU carry_in
psr_err  out  1  one-cycle registered pulse on rejected operation

Behaviour:
- Implemented bits: 31:28 (NZCV), 7 (I), 6 (F), 5 (T), 4:0 (mode). All other bits read 0 and are not stored.
- Reset (async): CPSR = RESET_CPSR; all SPSRs = 0; psr_err = 0.
- Legal modes:
  - USR 10000, FIQ 10001, IRQ 10010, SVC 10011, ABT 10111, UND 11011, SYS 11111.
  - SPSR-bearing modes: FIQ, IRQ, SVC, ABT, UND.
- All updates are registered. cpsr, spsr, carry_flag and cond_pass reflect the new value the cycle after the strobe.
- cond_pass is combinational from the registered CPSR.
- Per-cycle priority: exc_enter > spsr_restore > msr_we > t_we > alu_flags_we. Only the highest asserted operation takes effect; lower ones are dropped silently.
- exc_enter:
  - If exc_mode is an SPSR-bearing mode: SPSR[exc_mode] <= old CPSR; mode <= exc_mode; I <= 1; F <= 1 if exc_set_f, else unchanged; T <= 0; flags unchanged.
  - Otherwise: no state change, psr_err pulses.
- spsr_restore:
  - In USR/SYS: no-op, psr_err pulses.
  - Otherwise: CPSR <= current SPSR. If the SPSR mode field is illegal, mode is kept, all other bits are copied, and psr_err pulses.
- msr_we to CPSR:
  - Mask f writes bits 31:28.
  - Mask c writes I, F and mode, only when not in USR. In USR, mask c is ignored without error.
  - T is never written by MSR.
  - An illegal mode value leaves mode unchanged while I/F are still written; psr_err pulses.
  - Masks s and x have no effect.
- msr_we to SPSR:
  - In USR/SYS: no-op, psr_err pulses.
  - Otherwise: masked fields written to the current mode's SPSR, including T. An illegal mode value leaves the SPSR mode field unchanged; psr_err pulses.
- t_we: T <= t_val.
- alu_flags_we: NZCV <= alu_n, alu_z, alu_c, alu_v.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 0 (NV treated as never).
- psr_err is asserted exactly one cycle after the offending strobe, otherwise 0.
- Reset asserted mid-operation overrides everything immediately.

Test Plan:
- Reset: assert rst -> cpsr=0x000000D3, spsr=0, carry_flag=0, cond_pass=1 for cond=1110 and 0 for cond=0000; after release, values are held.
- ALU flags: alu_flags_we with N=0 Z=1 C=1 V=0 -> next cycle cpsr=0x600000D3, carry_flag=1; cond EQ=1, HI=0, LS=1, GE=1.
- IRQ entry: from cpsr=0x600000D3 (reset, then ALU flags write as above), exc_enter with exc_mode=10010, exc_set_f=0 -> cpsr=0x600000D2, spsr=0x600000D3; then spsr_restore -> cpsr=0x600000D3.
- USR restrictions: MSR CPSR=0x00000010, mask=0001 from SVC -> cpsr=0x00000010. Then MSR data 0xF00000DF, mask=1001 -> cpsr=0xF0000010, no error. Then msr_spsr=1 -> psr_err pulse, state unchanged.
- Priority: exc_enter(UND 11011) together with msr_we and alu_flags_we -> only entry applied (mode=11011, spsr=old CPSR), flags unchanged.
- Errors: exc_enter with exc_mode=10000 -> psr_err one cycle, no change. MSR CPSR mode=10101 mask=0001 in SVC -> I/F written, mode stays 10011, psr_err pulse.
